// File: rtl/cpu_types_pkg.sv
// Shared CPU types: BTB defaults and the packed BTB entry layout.
// Entry fields are sized for the widest legal configuration; narrower BTBs use the low bits.
package cpu_types_pkg;

    localparam int BTB_ENTRIES_DEF  = 16;
    localparam int BTB_CTR_BITS_DEF = 2;
    localparam int BTB_TAG_W_MAX    = 28;
    localparam int BTB_CTR_W_MAX    = 8;

    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_W_MAX-1:0] tag;
        logic [BTB_CTR_W_MAX-1:0] ctr;
        logic [31:0]              target;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter next-state logic; holds at all-ones and at zero.
module sat_counter #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] value,
    input  logic             inc,
    input  logic             dec,
    input  logic             en,
    output logic [WIDTH-1:0] next
);

    // Next value; conflicting inc/dec requests leave the count unchanged
    always_comb begin
        next = value;
        if (en && inc && !dec) begin
            if (value != {WIDTH{1'b1}}) begin
                next = value + WIDTH'(1);
            end else begin
                next = value;
            end
        end else if (en && dec && !inc) begin
            if (value != {WIDTH{1'b0}}) begin
                next = value - WIDTH'(1);
            end else begin
                next = value;
            end
        end else begin
            next = value;
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational off the stored state; updates land on the next rising edge.
module btb_predictor
    import cpu_types_pkg::*;
#(
    parameter  int ENTRIES  = BTB_ENTRIES_DEF,
    parameter  int CTR_BITS = BTB_CTR_BITS_DEF,
    localparam int IDX_W    = $clog2(ENTRIES),
    localparam int TAG_W    = 30 - IDX_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [31:0]      lookup_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic [IDX_W-1:0] pred_index,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_mispredict,
    input  logic             flush,
    output logic [15:0]      miss_count
);

    localparam logic [CTR_BITS-1:0] WEAK_TAKEN = CTR_BITS'(1) << (CTR_BITS - 1);

    btb_entry_t entries_r [ENTRIES];

    logic [IDX_W-1:0]    lk_idx_s;
    logic [TAG_W-1:0]    lk_tag_s;
    btb_entry_t          lk_entry_s;
    logic [IDX_W-1:0]    up_idx_s;
    logic [TAG_W-1:0]    up_tag_s;
    btb_entry_t          up_entry_s;
    logic                up_hit_s;
    logic [CTR_BITS-1:0] ctr_next_s;
    logic                wr_en_s;
    btb_entry_t          wr_entry_s;
    logic                unused_s;

    assign lk_idx_s   = lookup_pc[IDX_W+1:2];
    assign lk_tag_s   = lookup_pc[31:IDX_W+2];
    assign lk_entry_s = entries_r[lk_idx_s];
    assign up_idx_s   = upd_pc[IDX_W+1:2];
    assign up_tag_s   = upd_pc[31:IDX_W+2];
    assign up_entry_s = entries_r[up_idx_s];
    assign up_hit_s   = up_entry_s.valid && (up_entry_s.tag == BTB_TAG_W_MAX'(up_tag_s));
    assign unused_s   = ^{upd_pc[1:0], lk_entry_s.ctr, up_entry_s.ctr};

    // Lookup reads stored state only, so a same-cycle update is not visible until the next edge
    always_comb begin
        pred_index = lk_idx_s;
        pred_hit   = lk_entry_s.valid && (lk_entry_s.tag == BTB_TAG_W_MAX'(lk_tag_s));
        pred_taken = pred_hit && lk_entry_s.ctr[CTR_BITS-1];
        if (pred_taken) begin
            pred_target = lk_entry_s.target;
        end else begin
            pred_target = lookup_pc + 32'd4;
        end
    end

    sat_counter #(
        .WIDTH (CTR_BITS)
    ) u_sat_counter (
        .value (up_entry_s.ctr[CTR_BITS-1:0]),
        .inc   (upd_taken),
        .dec   (!upd_taken),
        .en    (up_hit_s),
        .next  (ctr_next_s)
    );

    // Write-port request: train on a hit, allocate only on a taken miss, never while flushing
    always_comb begin
        wr_en_s    = 1'b0;
        wr_entry_s = up_entry_s;
        if (upd_valid && !flush) begin
            if (up_hit_s) begin
                wr_en_s                       = 1'b1;
                wr_entry_s.ctr                = '0;
                wr_entry_s.ctr[CTR_BITS-1:0]  = ctr_next_s;
                if (upd_taken) begin
                    wr_entry_s.target = upd_target;
                end else begin
                    wr_entry_s.target = up_entry_s.target;
                end
            end else if (upd_taken) begin
                wr_en_s                       = 1'b1;
                wr_entry_s.valid              = 1'b1;
                wr_entry_s.tag                = BTB_TAG_W_MAX'(up_tag_s);
                wr_entry_s.ctr                = '0;
                wr_entry_s.ctr[CTR_BITS-1:0]  = WEAK_TAKEN;
                wr_entry_s.target             = upd_target;
            end else begin
                wr_en_s = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Entry storage: flush clears every valid bit and suppresses the write
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_r[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_r[i].valid <= 1'b0;
            end
        end else if (wr_en_s) begin
            entries_r[up_idx_s] <= wr_entry_s;
        end
    end

    // Mispredict statistics survive flush and stick at all-ones
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            miss_count <= 16'h0000;
        end else if (upd_valid && upd_mispredict && (miss_count != 16'hFFFF)) begin
            miss_count <= miss_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor (ENTRIES=16, CTR_BITS=2) with an independent behavioural model.
module tb_btb_predictor;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic [3:0]  index;
        logic [15:0] miss;
    } obs_t;

    typedef struct packed {
        logic [31:0] lpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        umis;
        logic        fl;
    } row_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] lookup_pc = 32'h0;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic [3:0]  pred_index;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'h0;
    logic        upd_mispredict = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] miss_count;

    int   n_cmp = 0;
    int   n_fail = 0;
    obs_t sb[$];
    obs_t exp_v, obs_v;

    // Reference model state
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    int          m_ctr   [16];
    logic [31:0] m_tgt   [16];
    int          m_miss;

    btb_predictor #(.ENTRIES(16), .CTR_BITS(2)) dut (
        .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .pred_index(pred_index), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush(flush), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_ctr[i] = 0; m_tgt[i] = '0;
        end
        m_miss = 0;
    endfunction

    function automatic obs_t model_predict(logic [31:0] pc);
        obs_t o;
        int   idx = int'(pc[5:2]);
        o.hit    = m_valid[idx] && (m_tag[idx] == pc[31:6]);
        o.taken  = o.hit && (m_ctr[idx] >= 2);
        o.target = o.taken ? m_tgt[idx] : pc + 32'd4;
        o.index  = pc[5:2];
        o.miss   = 16'(m_miss);
        return o;
    endfunction

    function automatic void model_update(row_t r);
        int idx = int'(r.upc[5:2]);
        bit hit = m_valid[idx] && (m_tag[idx] == r.upc[31:6]);
        if (r.uv && r.umis && m_miss < 65535) m_miss++;
        if (r.fl) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end else if (r.uv) begin
            if (hit) begin
                if (r.ut) begin
                    if (m_ctr[idx] < 3) m_ctr[idx]++;
                    m_tgt[idx] = r.utgt;
                end else if (m_ctr[idx] > 0) begin
                    m_ctr[idx]--;
                end
            end else if (r.ut) begin
                m_valid[idx] = 1'b1; m_tag[idx] = r.upc[31:6];
                m_ctr[idx] = 2; m_tgt[idx] = r.utgt;
            end
        end
    endfunction

    // Apply one row at the falling edge and queue the prediction expected this cycle
    task automatic drive(row_t r);
        @(negedge CLK);
        lookup_pc = r.lpc; upd_valid = r.uv; upd_pc = r.upc; upd_taken = r.ut;
        upd_target = r.utgt; upd_mispredict = r.umis; flush = r.fl;
        sb.push_back(model_predict(r.lpc));
        model_update(r);
    endtask

    function automatic row_t look(logic [31:0] pc);
        return '{lpc: pc, uv: 1'b0, upc: 32'h0, ut: 1'b0, utgt: 32'h0, umis: 1'b0, fl: 1'b0};
    endfunction

    function automatic row_t upd(logic [31:0] lpc, logic [31:0] pc, logic t, logic [31:0] tgt, logic fl);
        return '{lpc: lpc, uv: 1'b1, upc: pc, ut: t, utgt: tgt, umis: 1'b0, fl: fl};
    endfunction

    task automatic test_reset();
        model_reset();
        for (int k = 0; k < 2; k++) begin
            drive(look(32'h40));
            #1;
            exp_v = sb.pop_front();
            obs_v = {pred_hit, pred_taken, pred_target, pred_index, miss_count};
            n_cmp++;
            if (obs_v !== exp_v || exp_v !== {1'b0, 1'b0, 32'h44, 4'h0, 16'h0}) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h expected %h", k, obs_v, exp_v);
            end
            nRST = 1'b1;
        end
    endtask

    task automatic test_basic();
        row_t rows[$];
        rows.push_back(upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b0));
        rows.push_back(look(32'h40));
        rows.push_back(upd(32'h40, 32'h40, 1'b0, 32'h0, 1'b0));
        rows.push_back(look(32'h40));
        for (int k = 0; k < 3; k++) rows.push_back(upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b0));
        rows.push_back(look(32'h40));
        rows.push_back(upd(32'h40, 32'h40, 1'b0, 32'h0, 1'b0));
        rows.push_back(look(32'h40));
        for (int k = 0; k < 4; k++) rows.push_back(upd(32'h40, 32'h40, 1'b0, 32'h0, 1'b0));
        rows.push_back(upd(32'h40, 32'h40, 1'b1, 32'h180, 1'b0));
        rows.push_back(look(32'h40));
        rows.push_back(upd(32'h40, 32'h40, 1'b1, 32'h180, 1'b0));
        rows.push_back(look(32'h40));
        rows.push_back(look(32'h3C));
        foreach (rows[i]) begin
            drive(rows[i]);
            #1;
            exp_v = sb.pop_front();
            obs_v = {pred_hit, pred_taken, pred_target, pred_index, miss_count};
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL basic[%0d]: got %h expected %h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_alias();
        row_t rows[$];
        rows.push_back(upd(32'h40, 32'h80, 1'b1, 32'h200, 1'b0));
        rows.push_back(look(32'h40));
        rows.push_back(look(32'h80));
        rows.push_back(upd(32'hC4, 32'hC4, 1'b0, 32'h900, 1'b0));
        rows.push_back(look(32'hC4));
        rows.push_back(upd(32'h48, 32'h48, 1'b1, 32'h4000, 1'b0));
        rows.push_back(look(32'h48));
        rows.push_back(look(32'hFFFF_FFFC));
        foreach (rows[i]) begin
            drive(rows[i]);
            #1;
            exp_v = sb.pop_front();
            obs_v = {pred_hit, pred_taken, pred_target, pred_index, miss_count};
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL alias[%0d]: got %h expected %h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_same_cycle();
        row_t rows[$];
        rows.push_back(upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b0));
        rows.push_back(upd(32'h40, 32'h40, 1'b0, 32'h0, 1'b0));
        rows.push_back(upd(32'h40, 32'h40, 1'b1, 32'h140, 1'b0));
        rows.push_back(look(32'h40));
        foreach (rows[i]) begin
            drive(rows[i]);
            #1;
            exp_v = sb.pop_front();
            obs_v = {pred_hit, pred_taken, pred_target, pred_index, miss_count};
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL same_cycle[%0d]: got %h expected %h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_flush();
        row_t rows[$];
        rows.push_back(look(32'h48));
        rows.push_back(upd(32'h40, 32'h40, 1'b1, 32'h300, 1'b1));
        rows.push_back(look(32'h40));
        rows.push_back(look(32'h48));
        rows.push_back(look(32'h80));
        foreach (rows[i]) begin
            drive(rows[i]);
            #1;
            exp_v = sb.pop_front();
            obs_v = {pred_hit, pred_taken, pred_target, pred_index, miss_count};
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL flush[%0d]: got %h expected %h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_update();
        row_t r;
        r = upd(32'h300, 32'h300, 1'b1, 32'h500, 1'b0);
        r.umis = 1'b1;
        drive(r);
        nRST = 1'b0;
        model_reset();
        sb.delete();
        sb.push_back(model_predict(32'h300));
        #1;
        exp_v = sb.pop_front();
        obs_v = {pred_hit, pred_taken, pred_target, pred_index, miss_count};
        n_cmp++;
        if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_mid: got %h expected %h", obs_v, exp_v);
        end
        upd_valid = 1'b0; upd_mispredict = 1'b0;
        @(posedge CLK);
        #2 nRST = 1'b1;
        drive(look(32'h300));
        #1;
        exp_v = sb.pop_front();
        obs_v = {pred_hit, pred_taken, pred_target, pred_index, miss_count};
        n_cmp++;
        if (obs_v !== exp_v || pred_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got %h expected %h", obs_v, exp_v);
        end
    endtask

    task automatic test_miss_count();
        row_t r;
        for (int k = 0; k < 65545; k++) begin
            r = upd(32'h10, 32'h20, 1'b0, 32'h0, 1'b0);
            r.umis = 1'b1;
            if (k == 3) r.uv = 1'b0;
            if (k > 5 && k < 8) r.fl = 1'b1;
            drive(r);
            #1;
            exp_v = sb.pop_front();
            obs_v = {pred_hit, pred_taken, pred_target, pred_index, miss_count};
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL miss_count[%0d]: got %h expected %h", k, obs_v, exp_v);
            end
        end
        drive(look(32'h10));
        #1;
        exp_v = sb.pop_front();
        n_cmp++;
        if (miss_count !== exp_v.miss || miss_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL miss_sat: got %h expected %h", miss_count, exp_v.miss);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alias();
        test_same_cycle();
        test_flush();
        test_reset_mid_update();
        test_miss_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning number of BTB entries; power of two, minimum 4.
REQ-002 SHALL have parameter CTR_BITS, default 2, meaning width of each saturating direction counter; minimum 1.
REQ-003 SHALL derive IDX_W = log2(ENTRIES) and TAG_W = 30 - IDX_W as localparams.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 nRST  input  1  reset, asynchronous, active-low.
REQ-006 lookup_pc  input  32  fetch address being predicted.
REQ-007 pred_hit  output  1  valid entry with matching tag found.
REQ-008 pred_taken  output  1  predict taken.
REQ-009 pred_target  output  32  next fetch address.
REQ-010 pred_index  output  IDX_W  index used by the lookup, carried down the pipe.
REQ-011 upd_valid  input  1  resolved branch update this cycle.
REQ-012 upd_pc  input  32  address of the resolved branch.
REQ-013 upd_taken  input  1  actual branch outcome.
REQ-014 upd_target  input  32  actual branch target.
REQ-015 upd_mispredict  input  1  the pipeline flushed for this branch.
REQ-016 flush  input  1  synchronous invalidate of all entries.
REQ-017 miss_count  output  16  saturating mispredict counter.

Function
REQ-018 Index SHALL be pc[IDX_W+1:2] and tag SHALL be pc[31:IDX_W+2], for both lookup and update.
REQ-019 Lookup SHALL be combinational, zero latency: pred_hit = valid[idx] & (tag[idx] == lookup tag).
REQ-020 pred_taken SHALL be pred_hit & counter[idx] MSB.
REQ-021 pred_target SHALL be target[idx] when pred_taken, else lookup_pc + 4, computed modulo 2^32.
REQ-022 pred_index SHALL equal the lookup index regardless of hit.
REQ-023 Update, upd_valid=1, hit on upd_pc: counter SHALL increment when taken and saturate at 2^CTR_BITS-1, decrement when not taken and saturate at 0; target SHALL be overwritten only when taken.
REQ-024 Update, upd_valid=1, miss, taken: entry SHALL be allocated/replaced with valid=1, new tag, upd_target, counter = weakly taken (1<<(CTR_BITS-1)).
REQ-025 Update, upd_valid=1, miss, not taken: no state change.
REQ-026 Lookup and update to the same index in the same cycle: lookup SHALL return pre-update contents (no bypass).
REQ-027 flush=1: all valid bits SHALL clear at the next edge; flush SHALL win over a simultaneous update (no write); counters, tags and targets are don't-care.
REQ-028 miss_count SHALL increment by 1 on each edge with upd_valid & upd_mispredict, and saturate at 16'hFFFF; flush SHALL NOT clear it.
REQ-029 upd_mispredict with upd_valid=0 SHALL be ignored.

Reset
REQ-030 nRST low SHALL immediately clear all valid bits, counters, tags, targets and miss_count.
REQ-031 During and after reset, pred_hit=0, pred_taken=0, pred_target=lookup_pc+4, and pred_index=the lookup index.
REQ-032 Reset asserted mid-update SHALL leave no partial entry written.

Structure
REQ-033 Defaults for ENTRIES and CTR_BITS, and a packed btb_entry_t (valid, tag, ctr, target), SHALL live in cpu_types_pkg.
REQ-034 A single sub-module sat_counter, parametrised by width, with inputs inc/dec/en and a saturating output, SHALL implement the counter next-state logic.
REQ-035 Storage SHALL be flip-flops, with one read port and one write port.

Verification (ENTRIES=16, CTR_BITS=2)
REQ-036 After reset, lookup_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44, pred_index=0, miss_count=0.
REQ-037 Update 0x40 taken with target 0x100; next cycle lookup 0x40 -> hit=1, taken=1, target=0x100. Then one not-taken update -> taken=0, target=0x44. Then three taken updates -> counter 01→10→11→11, taken=1.
REQ-038 With 0x40 allocated, update 0x80 taken with target 0x200 (same index 0, different tag) -> lookup 0x40 misses; lookup 0x80 hits with target 0x200. A not-taken update to unallocated 0xC4 -> lookup 0xC4 still misses.
REQ-039 Update 0x40 taken with flush=1 in the same cycle -> lookup 0x40 misses; all previously valid entries miss.
REQ-040 Update to 0x40 while looking up 0x40 in the same cycle -> old prediction shown that cycle, new prediction the next cycle.
REQ-041 Three upd_valid & upd_mispredict pulses plus one upd_mispredict with upd_valid=0 -> miss_count=3. Forcing 0xFFFF then one more pulse -> miss_count stays 0xFFFF.
